// File: rtl/fpmul_queue_wrapper.sv
// Queued, memory-mapped front end for a multi-cycle single-precision multiplier.
// Command and result FIFOs decouple the host bus from the FPMUL sequencer.

module fpmul_core #(
  parameter int LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] p,
  output logic [5:0]  flags,
  output logic        done
);
  localparam logic [2:0] LAT_C = 3'(LAT);

  logic [31:0] a_q, a_d, b_q, b_d, p_q, p_d;
  logic [5:0]  flags_q, flags_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [2:0]  cnt_q, cnt_d;

  logic [7:0]  ea, eb;
  logic [22:0] fa, fb, frac_t;
  logic        sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_den, b_den;
  logic [47:0] prod;
  logic        norm, g, st, rnd;
  logic [23:0] frac_r;
  logic [9:0]  e_t;
  logic [31:0] mul_p;
  logic [5:0]  mul_f;

  assign ea     = a_q[30:23];
  assign eb     = b_q[30:23];
  assign fa     = a_q[22:0];
  assign fb     = b_q[22:0];
  assign sign   = a_q[31] ^ b_q[31];
  assign a_nan  = (ea == 8'hFF) && (fa != '0);
  assign b_nan  = (eb == 8'hFF) && (fb != '0);
  assign a_inf  = (ea == 8'hFF) && (fa == '0);
  assign b_inf  = (eb == 8'hFF) && (fb == '0);
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign a_den  = a_zero && (fa != '0);
  assign b_den  = b_zero && (fb != '0);

  // Flags {OF,UF,NANF,INFF,DNF,ZF}; denormal inputs flush to zero, rounding is nearest-even.
  // e_t carries a bias of 254 from the two input exponents, so the result field is e_t-127.
  always_comb begin
    prod   = 48'({1'b1, fa}) * 48'({1'b1, fb});
    norm   = prod[47];
    frac_t = norm ? prod[46:24] : prod[45:23];
    g      = norm ? prod[23] : prod[22];
    st     = norm ? |prod[22:0] : |prod[21:0];
    rnd    = g & (st | frac_t[0]);
    frac_r = {1'b0, frac_t} + 24'(rnd);
    e_t    = 10'(ea) + 10'(eb) + 10'(norm) + 10'(frac_r[23]);
    mul_p  = '0;
    mul_f  = '0;
    mul_f[1] = a_den | b_den;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      mul_p    = 32'h7FC0_0000;
      mul_f[3] = 1'b1;
    end else if (a_inf || b_inf) begin
      mul_p    = {sign, 8'hFF, 23'b0};
      mul_f[2] = 1'b1;
    end else if (a_zero || b_zero) begin
      mul_p    = {sign, 31'b0};
      mul_f[0] = 1'b1;
    end else if (e_t >= 10'd382) begin
      mul_p    = {sign, 8'hFF, 23'b0};
      mul_f[5] = 1'b1;
      mul_f[2] = 1'b1;
    end else if (e_t <= 10'd127) begin
      mul_p    = {sign, 31'b0};
      mul_f[4] = 1'b1;
      mul_f[0] = 1'b1;
    end else begin
      mul_p = {sign, 8'(e_t - 10'd127), frac_r[22:0]};
    end
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    if (start) begin
      a_d    = a;
      b_d    = b;
      busy_d = 1'b1;
      cnt_d  = LAT_C;
    end else if (busy_q) begin
      if (cnt_q == 3'd1) begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        p_d     = mul_p;
        flags_d = mul_f;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      flags_q <= flags_d;
      done_q  <= done_d;
    end
  end

  assign p     = p_q;
  assign flags = flags_q;
  assign done  = done_q;
endmodule

module fpmul_queue_wrapper #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic [2:0]    A,
  input  logic          WE,
  input  logic          RE,
  input  logic [DW-1:0] InData,
  output logic [DW-1:0] OutData,
  output logic          irq,
  output logic          done_sig
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     opa_q, opa_d, opb_q, opb_d, res_p_q, res_p_d;
  logic [5:0]        res_f_q, res_f_d;
  logic              irq_en_q, irq_en_d, ovf_q, ovf_d, unf_q, unf_d;
  logic [PW-1:0]     cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
  logic [PW-1:0]     res_wr_q, res_wr_d, res_rd_q, res_rd_d;
  logic [CNT_W-1:0]  cmd_cnt_q, cmd_cnt_d, res_cnt_q, res_cnt_d;
  logic [2*DW-1:0]   cmd_mem_q [DEPTH];
  logic [DW+5:0]     res_mem_q [DEPTH];

  logic wr_opa, wr_opb, wr_ctrl, rd_pop, flush, err_clr;
  logic cmd_full, res_empty, cmd_push, cmd_pop, res_push, res_pop, busy;
  logic core_start, core_done;
  logic [31:0] core_p;
  logic [5:0]  core_flags;
  logic [2*DW-1:0] cmd_head;
  logic [DW+5:0]   res_head;

  assign wr_opa    = WE && (A == 3'd0);
  assign wr_opb    = WE && (A == 3'd1);
  assign wr_ctrl   = WE && (A == 3'd5);
  assign rd_pop    = RE && (A == 3'd2);
  assign flush     = wr_ctrl && InData[1];
  assign err_clr   = wr_ctrl && InData[0];
  assign cmd_full  = (cmd_cnt_q == FULL);
  assign res_empty = (res_cnt_q == '0);
  assign cmd_push  = wr_opb && !cmd_full && !flush;
  assign res_pop   = rd_pop && !res_empty && !flush;
  assign cmd_head  = cmd_mem_q[cmd_rd_q];
  assign res_head  = res_mem_q[res_rd_q];
  assign busy      = (state_q != S_IDLE) || (cmd_cnt_q != '0);
  assign irq       = irq_en_q && !res_empty;
  assign done_sig  = res_push;

  fpmul_core #(.LAT(4)) u_core (
    .clk   (Clk),
    .rst   (~Rst_n),
    .start (core_start),
    .a     (cmd_head[2*DW-1:DW]),
    .b     (cmd_head[DW-1:0]),
    .p     (core_p),
    .flags (core_flags),
    .done  (core_done)
  );

  // A flush with Done in flight must still swallow that Done, hence DRAIN rather than IDLE.
  always_comb begin
    state_d    = state_q;
    core_start = 1'b0;
    cmd_pop    = 1'b0;
    res_push   = 1'b0;
    res_p_d    = res_p_q;
    res_f_d    = res_f_q;
    case (state_q)
      S_IDLE: begin
        if ((cmd_cnt_q != '0) && (res_cnt_q != FULL) && !flush) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        core_start = 1'b1;
        cmd_pop    = !flush;
        state_d    = flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          res_p_d = DW'(core_p);
          res_f_d = core_flags;
          state_d = flush ? S_IDLE : S_WB;
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_WB: begin
        res_push = !flush;
        state_d  = S_IDLE;
      end
      S_DRAIN: begin
        if (core_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    opa_d    = wr_opa ? InData : opa_q;
    opb_d    = wr_opb ? InData : opb_q;
    irq_en_d = wr_ctrl ? InData[2] : irq_en_q;
    ovf_d    = err_clr ? 1'b0 : (ovf_q | (wr_opb && cmd_full));
    unf_d    = err_clr ? 1'b0 : (unf_q | (rd_pop && res_empty));
    if (flush) begin
      cmd_wr_d  = '0;
      cmd_rd_d  = '0;
      cmd_cnt_d = '0;
      res_wr_d  = '0;
      res_rd_d  = '0;
      res_cnt_d = '0;
    end else begin
      cmd_wr_d  = cmd_wr_q + PW'(cmd_push);
      cmd_rd_d  = cmd_rd_q + PW'(cmd_pop);
      cmd_cnt_d = cmd_cnt_q + CNT_W'(cmd_push) - CNT_W'(cmd_pop);
      res_wr_d  = res_wr_q + PW'(res_push);
      res_rd_d  = res_rd_q + PW'(res_pop);
      res_cnt_d = res_cnt_q + CNT_W'(res_push) - CNT_W'(res_pop);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= S_IDLE;
      opa_q     <= '0;
      opb_q     <= '0;
      res_p_q   <= '0;
      res_f_q   <= '0;
      irq_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      cmd_wr_q  <= '0;
      cmd_rd_q  <= '0;
      cmd_cnt_q <= '0;
      res_wr_q  <= '0;
      res_rd_q  <= '0;
      res_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      res_p_q   <= res_p_d;
      res_f_q   <= res_f_d;
      irq_en_q  <= irq_en_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      cmd_wr_q  <= cmd_wr_d;
      cmd_rd_q  <= cmd_rd_d;
      cmd_cnt_q <= cmd_cnt_d;
      res_wr_q  <= res_wr_d;
      res_rd_q  <= res_rd_d;
      res_cnt_q <= res_cnt_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (cmd_push) cmd_mem_q[cmd_wr_q] <= {opa_q, InData};
    if (res_push) res_mem_q[res_wr_q] <= {res_p_q, res_f_q};
  end

  always_comb begin
    OutData = '0;
    case (A)
      3'd0: OutData = opa_q;
      3'd1: OutData = opb_q;
      3'd2: if (!res_empty) OutData = res_head[DW+5:6];
      3'd3: if (!res_empty) OutData = DW'(res_head[5:0]);
      3'd4: OutData = DW'({8'b0, 8'(cmd_cnt_q), 8'(res_cnt_q), 3'b0,
                           irq_en_q, busy, cmd_full, ovf_q, unf_q});
      3'd5: OutData = DW'({irq_en_q, 2'b0});
      default: OutData = '0;
    endcase
  end
endmodule

// File: tb/tb_fpmul_queue_wrapper.sv
// Scoreboard bench for fpmul_queue_wrapper: expected products queued on push,
// compared on pop; per-scenario tasks cover errors, flush, irq and async reset.

module tb_fpmul_queue_wrapper;
  localparam int DW = 32;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic [2:0]    A = '0;
  logic          WE = 1'b0;
  logic          RE = 1'b0;
  logic [DW-1:0] InData = '0;
  logic [DW-1:0] OutData;
  logic          irq;
  logic          done_sig;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [37:0] sb [$];

  fpmul_queue_wrapper #(.DW(32), .DEPTH(4), .CNT_W(3)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .A        (A),
    .WE       (WE),
    .RE       (RE),
    .InData   (InData),
    .OutData  (OutData),
    .irq      (irq),
    .done_sig (done_sig)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    #3;
    if (done_sig === 1'b1) done_cnt++;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Bus tasks start and end on a falling edge; the access lands on the rising edge between.
  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    A = addr; InData = data; WE = 1'b1;
    @(negedge Clk);
    WE = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] addr, input logic pop, output logic [31:0] data);
    A = addr; RE = pop;
    #1 data = OutData;
    @(negedge Clk);
    RE = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_p, input logic [5:0] exp_f);
    bus_write(3'd0, a);
    bus_write(3'd1, b);
    sb.push_back({exp_p, exp_f});
  endtask

  task automatic wait_res(input int n, input int budget);
    logic [31:0] st;
    int cyc;
    cyc = 0;
    bus_read(3'd4, 1'b0, st);
    while (int'(st[15:8]) < n && cyc < budget) begin
      bus_read(3'd4, 1'b0, st);
      cyc++;
    end
    checks++;
    if (int'(st[15:8]) < n) begin
      errors++;
      $display("[TB] FAIL wait_res: res_cnt=%0d required>=%0d within %0d cycles", st[15:8], n, budget);
    end
  endtask

  task automatic drain(input int n);
    logic [31:0] f, p;
    logic [37:0] exp;
    for (int i = 0; i < n; i++) begin
      wait_res(1, 60);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL scoreboard: result present but nothing expected");
      end else begin
        exp = sb.pop_front();
        bus_read(3'd3, 1'b0, f);
        checks++;
        if (f !== {26'b0, exp[5:0]}) begin
          errors++;
          $display("[TB] FAIL res_flags[%0d]: got %h required %h", i, f, {26'b0, exp[5:0]});
        end
        bus_read(3'd2, 1'b1, p);
        checks++;
        if (p !== exp[37:6]) begin
          errors++;
          $display("[TB] FAIL res_product[%0d]: got %h required %h", i, p, exp[37:6]);
        end
      end
    end
  endtask

  task automatic test_reset;
    Rst_n = 1'b0;
    idle(2);
    for (int a = 0; a < 8; a++) begin
      A = 3'(a);
      #1;
      checks++;
      if (OutData !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_read[%0d]: got %h required 00000000", a, OutData);
      end
    end
    checks++;
    if (irq !== 1'b0 || done_sig !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: irq=%b done_sig=%b required 0 0", irq, done_sig);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_single;
    logic [31:0] r;
    int d0;
    d0 = done_cnt;
    push_pair(32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 6'h00);
    wait_res(1, 40);
    idle(2);
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("[TB] FAIL single_done_pulses: got %0d required 1", done_cnt - d0);
    end
    bus_read(3'd0, 1'b0, r);
    checks++;
    if (r !== 32'h4040_0000) begin
      errors++;
      $display("[TB] FAIL opa_readback: got %h required 40400000", r);
    end
    bus_read(3'd1, 1'b0, r);
    checks++;
    if (r !== 32'h4000_0000) begin
      errors++;
      $display("[TB] FAIL opb_readback: got %h required 40000000", r);
    end
    drain(1);
    bus_read(3'd4, 1'b0, r);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("[TB] FAIL single_status_after_pop: got %h required 00000000", r);
    end
  endtask

  task automatic test_cmd_overflow;
    logic [31:0] st;
    push_pair(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 6'h00);
    push_pair(32'h4000_0000, 32'h3F00_0000, 32'h3F80_0000, 6'h00);
    push_pair(32'hC040_0000, 32'h4000_0000, 32'hC0C0_0000, 6'h00);
    push_pair(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 6'h24);
    wait_res(4, 120);
    bus_write(3'd0, 32'h3F80_0000);
    for (int i = 0; i < 5; i++) begin
      bus_write(3'd1, 32'h3F80_0000);
      if (i < 4) sb.push_back({32'h3F80_0000, 6'h00});
    end
    bus_read(3'd4, 1'b0, st);
    checks++;
    if (st !== 32'h0004_040E) begin
      errors++;
      $display("[TB] FAIL overflow_status: got %h required 0004040E", st);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL irq_disabled: got %b required 0", irq);
    end
    bus_write(3'd5, 32'h1);
    bus_read(3'd4, 1'b0, st);
    checks++;
    if (st !== 32'h0004_040C) begin
      errors++;
      $display("[TB] FAIL overflow_cleared: got %h required 0004040C", st);
    end
    drain(8);
    idle(2);
    bus_read(3'd4, 1'b0, st);
    checks++;
    if (st !== 32'h0) begin
      errors++;
      $display("[TB] FAIL overflow_final_status: got %h required 00000000", st);
    end
  endtask

  task automatic test_pop_empty;
    logic [31:0] r;
    bus_read(3'd2, 1'b1, r);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("[TB] FAIL empty_pop_data: got %h required 00000000", r);
    end
    bus_read(3'd4, 1'b0, r);
    checks++;
    if (r !== 32'h0000_0001) begin
      errors++;
      $display("[TB] FAIL underflow_status: got %h required 00000001", r);
    end
    push_pair(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 6'h11);
    push_pair(32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 6'h03);
    drain(2);
    bus_write(3'd5, 32'h1);
    bus_read(3'd4, 1'b0, r);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("[TB] FAIL underflow_cleared: got %h required 00000000", r);
    end
  endtask

  task automatic test_nan_irq;
    logic [31:0] r;
    bus_write(3'd5, 32'h4);
    bus_read(3'd5, 1'b0, r);
    checks++;
    if (r !== 32'h4) begin
      errors++;
      $display("[TB] FAIL ctrl_readback: got %h required 00000004", r);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL irq_when_empty: got %b required 0", irq);
    end
    push_pair(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 6'h08);
    wait_res(1, 40);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL irq_pending: got %b required 1", irq);
    end
    drain(1);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL irq_after_pop: got %b required 0", irq);
    end
  endtask

  task automatic test_flush;
    logic [31:0] st;
    int d0;
    push_pair(32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 6'h00);
    wait_res(1, 40);
    bus_write(3'd0, 32'h4000_0000);
    bus_write(3'd1, 32'h3F80_0000);
    bus_write(3'd1, 32'h4000_0000);
    bus_write(3'd1, 32'h4040_0000);
    d0 = done_cnt;
    bus_write(3'd5, 32'h2);
    sb.delete();
    idle(12);
    checks++;
    if (done_cnt !== d0) begin
      errors++;
      $display("[TB] FAIL flush_done_sig: got %0d pulses required 0", done_cnt - d0);
    end
    bus_read(3'd4, 1'b0, st);
    checks++;
    if (st !== 32'h0) begin
      errors++;
      $display("[TB] FAIL flush_status: got %h required 00000000", st);
    end
    push_pair(32'h4000_0000, 32'h3F00_0000, 32'h3F80_0000, 6'h00);
    wait_res(1, 40);
    idle(1);
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("[TB] FAIL post_flush_done: got %0d required 1", done_cnt - d0);
    end
    drain(1);
  endtask

  task automatic test_reset_mid;
    logic [31:0] st;
    int d0;
    bus_write(3'd5, 32'h4);
    push_pair(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 6'h00);
    wait_res(1, 40);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL irq_before_reset: got %b required 1", irq);
    end
    bus_write(3'd0, 32'h4040_0000);
    bus_write(3'd1, 32'h4040_0000);
    idle(2);
    A = 3'd4;
    #2 Rst_n = 1'b0;
    #1;
    checks++;
    if (OutData !== 32'h0 || irq !== 1'b0 || done_sig !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: status=%h irq=%b done_sig=%b required 00000000 0 0", OutData, irq, done_sig);
    end
    A = 3'd0;
    #1;
    checks++;
    if (OutData !== 32'h0) begin
      errors++;
      $display("[TB] FAIL async_reset_opa: got %h required 00000000", OutData);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    sb.delete();
    d0 = done_cnt;
    idle(12);
    checks++;
    if (done_cnt !== d0) begin
      errors++;
      $display("[TB] FAIL lost_inflight: got %0d pulses required 0", done_cnt - d0);
    end
    bus_read(3'd4, 1'b0, st);
    checks++;
    if (st !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_status: got %h required 00000000", st);
    end
    push_pair(32'hC040_0000, 32'h4000_0000, 32'hC0C0_0000, 6'h00);
    drain(1);
  endtask

  initial begin
    @(negedge Clk);
    test_reset();
    test_single();
    test_cmd_overflow();
    test_pop_empty();
    test_nan_irq();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
